hazard_stall_ctrl: RTL

- Parametrised next-generation hazard/stall controller for the 5-stage core, sitting between the ID/EX pipeline registers, the NPU queue interface and the I/D caches.
- Extends load-use detection to multi-cycle loads through a small pending-load scoreboard, and generalises NPU hazards to N queues.
- Adds an r0 exemption, a cache-stall watchdog FSM with a sticky timeout flag, and saturating stall performance counters.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_stall_ctrl_load_scoreboard.sv | 71 +++++++
 rtl/hazard_stall_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard/stall controller slice.
// Holds the NPU queue indices, the watchdog state encoding and a small cache-miss helper.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF    = 5;
    localparam int unsigned NUM_NPU_Q_DEF = 3;

    localparam int unsigned NPU_Q_CFG = 0;
    localparam int unsigned NPU_Q_IN  = 1;
    localparam int unsigned NPU_Q_OUT = 2;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        TOUT = 2'd2
    } wdState_e;

    function automatic logic cacheMiss(input logic instrValid, input logic instrReady,
                                       input logic dataValid, input logic dataReady);
        return (instrValid & ~instrReady) | (dataValid & ~dataReady);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_load_scoreboard.sv
// Pending-load scoreboard: tracks loads still inside their no-forward window and
// flags any used ID source register that matches the EX load or a pending entry.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = REG_AW_DEF,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      hold,
    input  logic                      ldEx,
    input  logic [REG_AW-1:0]         exRegRt,
    input  logic [NUM_SRC*REG_AW-1:0] idRegSrc,
    input  logic [NUM_SRC-1:0]        idSrcUsed,
    output logic                      dataHazard
);

    logic [NUM_SRC-1:0] exHit;
    logic [NUM_SRC-1:0] sbHit;

    always_comb begin
        exHit = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            exHit[k] = ldEx && (idRegSrc[k*REG_AW +: REG_AW] == exRegRt)
                       && (idRegSrc[k*REG_AW +: REG_AW] != '0);
        end
    end

    generate
        if (LOAD_LAT > 0) begin : gSb
            logic [LOAD_LAT-1:0] entValid;
            logic [REG_AW-1:0]   entReg [LOAD_LAT];

            // Holds only on a full stall; a semi stall still lets the EX load advance.
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    entValid <= '0;
                    for (int unsigned j = 0; j < LOAD_LAT; j++) begin
                        entReg[j] <= '0;
                    end
                end else if (!hold) begin
                    entValid[0] <= ldEx;
                    entReg[0]   <= exRegRt;
                    for (int unsigned j = 1; j < LOAD_LAT; j++) begin
                        entValid[j] <= entValid[j-1];
                        entReg[j]   <= entReg[j-1];
                    end
                end
            end

            always_comb begin
                sbHit = '0;
                for (int unsigned k = 0; k < NUM_SRC; k++) begin
                    for (int unsigned j = 0; j < LOAD_LAT; j++) begin
                        if (entValid[j] && (entReg[j] == idRegSrc[k*REG_AW +: REG_AW])
                            && (idRegSrc[k*REG_AW +: REG_AW] != '0)) begin
                            sbHit[k] = 1'b1;
                        end
                    end
                end
            end
        end else begin : gNoSb
            assign sbHit = '0;
        end
    endgenerate

    assign dataHazard = |(idSrcUsed & (exHit | sbHit));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use and NPU/cache stall generation, cache-stall
// watchdog with sticky timeout, and saturating stall-cycle counters.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW    = REG_AW_DEF,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned NUM_NPU_Q = NUM_NPU_Q_DEF,
    parameter int unsigned TO_CYC    = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                      iClk,
    input  logic                      iRst_n,
    input  logic [NUM_SRC*REG_AW-1:0] iIdRegSrc,
    input  logic [NUM_SRC-1:0]        iIdSrcUsed,
    input  logic [REG_AW-1:0]         iExRegRt,
    input  logic                      iExMemRead,
    input  logic                      iExRetCmd,
    input  logic                      iCacheFlush,
    input  logic [NUM_NPU_Q-1:0]      iExNpuOp,
    input  logic [NUM_NPU_Q-1:0]      iNpuBlocked,
    input  logic                      iInstrCacheValid,
    input  logic                      iInstrCacheReady,
    input  logic                      iDataCacheValid,
    input  logic                      iDataCacheReady,
    input  logic                      iErrClr,
    input  logic                      iCntClr,
    output logic                      oFullStall,
    output logic                      oSemiStall,
    output logic                      oCacheTimeout,
    output logic [CNT_W-1:0]          oSemiCnt,
    output logic [CNT_W-1:0]          oFullCnt
);

    localparam int unsigned WD_W = $clog2(TO_CYC);

    logic ldEx;
    logic dataHazard;
    logic npuHazard;
    logic cacheHazard;

    assign ldEx        = iExMemRead & ~iCacheFlush & ~iExRetCmd & (iExRegRt != '0);
    assign npuHazard   = |(iExNpuOp & iNpuBlocked);
    assign cacheHazard = cacheMiss(iInstrCacheValid, iInstrCacheReady,
                                   iDataCacheValid, iDataCacheReady);

    assign oFullStall = npuHazard | cacheHazard;
    assign oSemiStall = dataHazard & ~oFullStall;

    load_scoreboard #(
        .REG_AW   (REG_AW),
        .NUM_SRC  (NUM_SRC),
        .LOAD_LAT (LOAD_LAT)
    ) uScoreboard (
        .clk        (iClk),
        .rstN       (iRst_n),
        .hold       (oFullStall),
        .ldEx       (ldEx),
        .exRegRt    (iExRegRt),
        .idRegSrc   (iIdRegSrc),
        .idSrcUsed  (iIdSrcUsed),
        .dataHazard (dataHazard)
    );

    wdState_e        wdState, wdStateNext;
    logic [WD_W-1:0] wdCnt, wdCntNext;
    logic            toSet;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wdState       <= RUN;
            wdCnt         <= '0;
            oCacheTimeout <= 1'b0;
        end else begin
            wdState <= wdStateNext;
            wdCnt   <= wdCntNext;
            // Setting the flag outranks a simultaneous clear request.
            if (toSet) begin
                oCacheTimeout <= 1'b1;
            end else if (iErrClr) begin
                oCacheTimeout <= 1'b0;
            end
        end
    end

    always_comb begin
        wdStateNext = wdState;
        wdCntNext   = wdCnt;
        toSet       = 1'b0;
        unique case (wdState)
            RUN: begin
                if (cacheHazard) begin
                    wdStateNext = WAIT;
                    wdCntNext   = WD_W'(1);
                end
            end
            WAIT: begin
                if (!cacheHazard) begin
                    wdStateNext = RUN;
                    wdCntNext   = '0;
                end else if (wdCnt == WD_W'(TO_CYC - 1)) begin
                    wdStateNext = TOUT;
                    toSet       = 1'b1;
                end else begin
                    wdCntNext = wdCnt + 1'b1;
                end
            end
            TOUT: begin
                if (!cacheHazard) begin
                    wdStateNext = RUN;
                    wdCntNext   = '0;
                end
            end
            default: begin
                wdStateNext = RUN;
                wdCntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oSemiCnt <= '0;
            oFullCnt <= '0;
        end else if (iCntClr) begin
            oSemiCnt <= '0;
            oFullCnt <= '0;
        end else begin
            if (oSemiStall && (oSemiCnt != '1)) oSemiCnt <= oSemiCnt + 1'b1;
            if (oFullStall && (oFullCnt != '1)) oFullCnt <= oFullCnt + 1'b1;
        end
    end

endmodule
